mtrap_unit: RTL and testbench
=============================

Name: mtrap_unit

Overview:
- Receiving end of the trap-entry signals produced by the privileged trap-detection logic.
- Holds the machine trap CSRs: mstatus (MIE/MPIE/MPP), mtvec, mepc, mcause, mtval.
- Commits trap entry and mret return, then issues a single redirect PC to the frontend with a valid/ready handshake.
- Sits between commit/privileged logic and the fetch-flush path; also serves software CSR accesses to these five registers.

Parameters:
RESET_MTVEC, 64'h0000_0000_8000_0000, reset value of mtvec (bits [1:0] forced 00)
XLEN, 64, data width; only 64 supported

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-high reset
trap_valid  input  1  trap entry request
trap_ready  output  1  trap request accepted this cycle when high with trap_valid
trap_epc  input  64  faulting/interrupted PC
trap_cause  input  64  mcause value; bit63 = interrupt
trap_tval  input  64  mtval value
mret_valid  input  1  mret commit request
mret_ready  output  1  mret accepted this cycle when high with mret_valid
csr_wen  input  1  software CSR write strobe
csr_addr  input  12  CSR address for read and write
csr_wdata  input  64  CSR write data
csr_rdata  output  64  combinational read of csr_addr
mstatus_out  output  64  current mstatus view, to interrupt gating
redirect_valid  output  1  redirect PC valid
redirect_ready  input  1  frontend accepts redirect
redirect_pc  output  64  target PC
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset: mstatus.MIE=0, mstatus.MPIE=0, mepc=0, mcause=0, mtval=0, mtvec=RESET_MTVEC, FSM=IDLE, redirect_valid=0, redirect_pc=0, busy=0.
- trap_ready and mret_ready are high only in IDLE.
- FSM has two states, IDLE and REDIRECT.
- IDLE, trap_valid=1:
  - mepc<=trap_epc with bit0 cleared; mcause<=trap_cause; mtval<=trap_tval.
  - MPIE<=MIE; MIE<=0.
  - redirect_pc<=mtvec base ({mtvec[63:2],2'b00}).
  - Next state REDIRECT.
- IDLE, mret_valid=1 and no trap_valid:
  - MIE<=MPIE; MPIE<=1; redirect_pc<=mepc.
  - Next state REDIRECT.
- Both trap_valid and mret_valid in the same cycle: trap wins; mret_ready still reads 1, but mret is dropped (the caller treats it as flushed).
- REDIRECT:
  - redirect_valid=1; redirect_pc held stable.
  - On redirect_ready=1 the next state is IDLE and redirect_valid drops the next cycle.
  - New trap/mret requests are not accepted while in REDIRECT.
- Latency: request accepted in cycle N → redirect_valid high in cycle N+1; minimum 2 cycles request-to-request.
- CSR map: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343. Unmapped addresses read 0; writes to them are ignored.
- WARL rules:
  - mstatus: only MIE(bit3) and MPIE(bit7) are writable; MPP(bits12:11) always reads 2'b11; all other bits read 0.
  - mepc: bit0 always 0.
  - mtvec: bits[1:0] read 00 (see Optional Feature).
- CSR writes take effect at the clock edge and are accepted in any state.
- If a trap or mret updates a register in the same cycle as a CSR write to that register, the trap/mret value wins and the CSR write is lost. Writes to unaffected registers proceed.
- mstatus_out = current mstatus value, with the same masking as the mstatus read.
- Reset asserted mid-REDIRECT: immediate return to IDLE, redirect_valid=0 asynchronously, and all CSRs take their reset values.

Optional Feature:
MTVEC_VECTORED_EN
- Defined:
  - mtvec bit0 is writable (mode 1 = vectored).
  - When mode=1 and trap_cause[63]=1, redirect_pc = base + 4*trap_cause[5:0].
  - Exceptions always go to base.
- Undefined: mtvec bit0 is forced 0 and all traps go to base.

Test Plan:
- Reset, then read 0x305 → RESET_MTVEC; read 0x300 → 64'h1800; redirect_valid=0.
- Write 0x300=0x8; trap_valid with epc=0x8000_0101, cause=0x2, tval=0x13:
  - redirect_valid rises next cycle with pc=0x8000_0000.
  - mepc=0x8000_0100; mstatus reads 0x1880.
- After the trap above, pulse mret_valid:
  - redirect_pc=0x8000_0100.
  - mstatus reads 0x1888 (MIE=1, MPIE=1).
- Hold redirect_ready=0 for 5 cycles:
  - redirect_valid and pc stay stable; trap_ready=0 and busy=1 throughout.
  - Raise redirect_ready → IDLE next cycle.
- Same cycle: trap_valid, mret_valid and csr write 0x341=0x1234:
  - Trap wins; mepc=trap_epc; mret is ignored.
  - A separate-cycle write to 0x305 reads back with bits[1:0]=00 when MTVEC_VECTORED_EN is undefined.
- With MTVEC_VECTORED_EN defined, mtvec=0x8000_0001 and trap cause=0x8000_0000_0000_0007 → redirect_pc=0x8000_001C.

Source files
------------

// File: rtl/mtrap_unit.sv
// Machine-mode trap unit. It holds the machine trap CSRs (mstatus MIE/MPIE/MPP, mtvec, mepc,
// mcause, mtval), commits trap entry and mret return, and issues one redirect PC per event to
// the frontend over a valid/ready handshake. It also serves software CSR accesses to these
// registers.
// Optional feature macro: MTVEC_VECTORED_EN. When it is defined, mtvec bit0 selects vectored
// mode, and interrupts jump to base + 4*cause[5:0].
module mtrap_unit #(
    parameter logic [63:0] RESET_MTVEC = 64'h0000_0000_8000_0000,
    parameter int unsigned XLEN        = 64
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            trap_valid,
    output logic            trap_ready,
    input  logic [XLEN-1:0] trap_epc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_valid,
    output logic            mret_ready,
    input  logic            csr_wen,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic [XLEN-1:0] mstatus_out,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    localparam logic [11:0] AddrMstatus = 12'h300;
    localparam logic [11:0] AddrMtvec   = 12'h305;
    localparam logic [11:0] AddrMepc    = 12'h341;
    localparam logic [11:0] AddrMcause  = 12'h342;
    localparam logic [11:0] AddrMtval   = 12'h343;

    localparam logic [XLEN-1:0] MtvecReset = {RESET_MTVEC[XLEN-1:2], 2'b00};

    typedef enum logic [0:0] {StIdle, StRedirect} state_e;

    state_e          state_q, state_d;
    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic [XLEN-1:0] mstatus_view;
    logic [XLEN-1:0] mtvec_base;
    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] mtvec_wval;

    // MPP is hardwired to M-mode (2'b11). Only MIE and MPIE are live state.
    always_comb begin
        mstatus_view     = '0;
        mstatus_view[12] = 1'b1;
        mstatus_view[11] = 1'b1;
        mstatus_view[7]  = mpie_q;
        mstatus_view[3]  = mie_q;
    end

    // Trap target and mtvec WARL write value (mode bit only writable in vectored builds).
    always_comb begin
        mtvec_base  = {mtvec_q[XLEN-1:2], 2'b00};
        trap_target = mtvec_base;
`ifdef MTVEC_VECTORED_EN
        mtvec_wval  = {csr_wdata[XLEN-1:2], 1'b0, csr_wdata[0]};
        if (mtvec_q[0] && trap_cause[XLEN-1]) begin
            trap_target = mtvec_base + XLEN'({trap_cause[5:0], 2'b00});
        end
`else
        mtvec_wval  = {csr_wdata[XLEN-1:2], 2'b00};
`endif
    end

    // Combinational CSR read mux. Unmapped addresses read zero.
    always_comb begin
        csr_rdata = '0;
        unique case (csr_addr)
            AddrMstatus: csr_rdata = mstatus_view;
            AddrMtvec:   csr_rdata = mtvec_q;
            AddrMepc:    csr_rdata = mepc_q;
            AddrMcause:  csr_rdata = mcause_q;
            AddrMtval:   csr_rdata = mtval_q;
            default:     csr_rdata = '0;
        endcase
    end

    // Next state: software writes are applied first, so trap/mret updates override them.
    always_comb begin
        state_d       = state_q;
        mie_d         = mie_q;
        mpie_d        = mpie_q;
        mtvec_d       = mtvec_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mtval_d       = mtval_q;
        redirect_pc_d = redirect_pc_q;

        if (csr_wen) begin
            unique case (csr_addr)
                AddrMstatus: begin
                    mie_d  = csr_wdata[3];
                    mpie_d = csr_wdata[7];
                end
                AddrMtvec:  mtvec_d  = mtvec_wval;
                AddrMepc:   mepc_d   = {csr_wdata[XLEN-1:1], 1'b0};
                AddrMcause: mcause_d = csr_wdata;
                AddrMtval:  mtval_d  = csr_wdata;
                default: ;
            endcase
        end

        unique case (state_q)
            StIdle: begin
                if (trap_valid) begin
                    // A trap takes priority. A concurrent mret is dropped.
                    mepc_d        = {trap_epc[XLEN-1:1], 1'b0};
                    mcause_d      = trap_cause;
                    mtval_d       = trap_tval;
                    mpie_d        = mie_q;
                    mie_d         = 1'b0;
                    redirect_pc_d = trap_target;
                    state_d       = StRedirect;
                end else if (mret_valid) begin
                    mie_d         = mpie_q;
                    mpie_d        = 1'b1;
                    redirect_pc_d = mepc_q;
                    state_d       = StRedirect;
                end
            end
            StRedirect: begin
                if (redirect_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and CSR registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= StIdle;
            mie_q         <= 1'b0;
            mpie_q        <= 1'b0;
            mtvec_q       <= MtvecReset;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            mie_q         <= mie_d;
            mpie_q        <= mpie_d;
            mtvec_q       <= mtvec_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mtval_q       <= mtval_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign trap_ready     = (state_q == StIdle);
    assign mret_ready     = (state_q == StIdle);
    assign busy           = (state_q != StIdle);
    assign redirect_valid = (state_q == StRedirect);
    assign redirect_pc    = redirect_pc_q;
    assign mstatus_out    = mstatus_view;

endmodule

// File: tb/tb_mtrap_unit.sv
module tb_mtrap_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        trap_valid = 1'b0;
    logic        trap_ready;
    logic [63:0] trap_epc = '0;
    logic [63:0] trap_cause = '0;
    logic [63:0] trap_tval = '0;
    logic        mret_valid = 1'b0;
    logic        mret_ready;
    logic        csr_wen = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [63:0] csr_wdata = '0;
    logic [63:0] csr_rdata;
    logic [63:0] mstatus_out;
    logic        redirect_valid;
    logic        redirect_ready = 1'b1;
    logic [63:0] redirect_pc;
    logic        busy;

    mtrap_unit dut (
        .CLK            (CLK),
        .RST            (RST),
        .trap_valid     (trap_valid),
        .trap_ready     (trap_ready),
        .trap_epc       (trap_epc),
        .trap_cause     (trap_cause),
        .trap_tval      (trap_tval),
        .mret_valid     (mret_valid),
        .mret_ready     (mret_ready),
        .csr_wen        (csr_wen),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .mstatus_out    (mstatus_out),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    always #5 CLK = ~CLK;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned pops  = 0;
    int unsigned pushes = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
        end
    endtask

    // Monitor: samples mid low phase, after stimulus has settled.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (redirect_valid && redirect_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_redirect", redirect_pc, 64'hx);
                end else begin
                    chk("redirect_pc", redirect_pc, exp_q.pop_front());
                end
                pops++;
            end
        end
    end

    task automatic push(input logic [63:0] pc);
        exp_q.push_back(pc);
        pushes++;
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (pops >= pushes) break;
            @(negedge CLK);
            #3;
        end
        chk("drain_timeout", 64'(pops), 64'(pushes));
    endtask

    task automatic rd(input logic [11:0] a, input logic [63:0] exp, input string nm);
        csr_addr = a;
        #1;
        chk(nm, csr_rdata, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        @(negedge CLK);
        csr_wen = 1'b1; csr_addr = a; csr_wdata = d;
        @(negedge CLK);
        csr_wen = 1'b0;
    endtask

    task automatic issue_trap(input logic [63:0] epc, input logic [63:0] cause,
                              input logic [63:0] tval);
        @(negedge CLK);
        trap_valid = 1'b1; trap_epc = epc; trap_cause = cause; trap_tval = tval;
        @(negedge CLK);
        trap_valid = 1'b0;
    endtask

    task automatic issue_mret();
        @(negedge CLK);
        mret_valid = 1'b1;
        @(negedge CLK);
        mret_valid = 1'b0;
    endtask

    logic [63:0] held_pc;

    initial begin
        // Reset state
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_trap_ready", 64'(trap_ready), 64'd1);
        chk("rst_redirect_pc", redirect_pc, 64'd0);
        chk("rst_mstatus_out", mstatus_out, 64'h1800);
        rd(12'h305, 64'h8000_0000, "rst_mtvec");
        rd(12'h300, 64'h1800, "rst_mstatus");
        rd(12'h341, 64'h0, "rst_mepc");

        // Enable MIE then take an exception
        wr(12'h300, 64'h8);
        rd(12'h300, 64'h1808, "mstatus_mie_set");
        push(64'h8000_0000);
        issue_trap(64'h8000_0101, 64'h2, 64'h13);
        #1;
        chk("trap_latency_valid", 64'(redirect_valid), 64'd1);
        drain();
        rd(12'h341, 64'h8000_0100, "trap_mepc");
        rd(12'h300, 64'h1880, "trap_mstatus");
        rd(12'h342, 64'h2, "trap_mcause");
        rd(12'h343, 64'h13, "trap_mtval");

        // mret back
        push(64'h8000_0100);
        issue_mret();
        drain();
        rd(12'h300, 64'h1888, "mret_mstatus");
        chk("mret_mstatus_out", mstatus_out, 64'h1888);

        // Stalled redirect: nothing new accepted
        redirect_ready = 1'b0;
        push(64'h8000_0000);
        issue_trap(64'h200, 64'h8000_0000_0000_0003, 64'h0);
        held_pc = 64'h8000_0000;
        for (int i = 0; i < 5; i++) begin
            trap_valid = (i == 2); trap_epc = 64'hdead;
            #1;
            chk("stall_valid", 64'(redirect_valid), 64'd1);
            chk("stall_pc", redirect_pc, held_pc);
            chk("stall_trap_ready", 64'(trap_ready), 64'd0);
            chk("stall_mret_ready", 64'(mret_ready), 64'd0);
            chk("stall_busy", 64'(busy), 64'd1);
            @(negedge CLK);
        end
        trap_valid = 1'b0;
        redirect_ready = 1'b1;
        drain();
        @(negedge CLK);
        #1;
        chk("stall_release_busy", 64'(busy), 64'd0);
        chk("stall_release_valid", 64'(redirect_valid), 64'd0);
        rd(12'h341, 64'h200, "stall_mepc_kept");
        rd(12'h300, 64'h1880, "stall_mstatus");

        // Trap, mret and mepc write in one cycle
        push(64'h8000_0000);
        @(negedge CLK);
        trap_valid = 1'b1; trap_epc = 64'h3001; trap_cause = 64'h5; trap_tval = 64'h7;
        mret_valid = 1'b1;
        csr_wen = 1'b1; csr_addr = 12'h341; csr_wdata = 64'h1234;
        #1;
        chk("same_cycle_mret_ready", 64'(mret_ready), 64'd1);
        @(negedge CLK);
        trap_valid = 1'b0; mret_valid = 1'b0; csr_wen = 1'b0;
        drain();
        rd(12'h341, 64'h3000, "same_cycle_mepc");
        rd(12'h300, 64'h1800, "same_cycle_mstatus");
        rd(12'h342, 64'h5, "same_cycle_mcause");
        rd(12'h343, 64'h7, "same_cycle_mtval");

        // WARL readbacks
        wr(12'h305, 64'h8000_1003);
`ifdef MTVEC_VECTORED_EN
        rd(12'h305, 64'h8000_1001, "mtvec_warl");
`else
        rd(12'h305, 64'h8000_1000, "mtvec_warl");
`endif
        wr(12'h341, 64'h5555);
        rd(12'h341, 64'h5554, "mepc_warl");
        wr(12'h300, 64'hffff_ffff_ffff_ffff);
        rd(12'h300, 64'h1888, "mstatus_warl");
        wr(12'h344, 64'hffff);
        rd(12'h344, 64'h0, "unmapped_read");
        wr(12'h342, 64'habc);
        rd(12'h342, 64'habc, "mcause_write");

        // Interrupt with vectored mtvec
        wr(12'h305, 64'h8000_0001);
`ifdef MTVEC_VECTORED_EN
        push(64'h8000_001c);
`else
        push(64'h8000_0000);
`endif
        issue_trap(64'h400, 64'h8000_0000_0000_0007, 64'h0);
        drain();
        rd(12'h300, 64'h1880, "vec_mstatus");

        // Reset in the middle of a redirect
        redirect_ready = 1'b0;
        issue_trap(64'h500, 64'h4, 64'h9);
        #1;
        chk("pre_rst_valid", 64'(redirect_valid), 64'd1);
        #1;
        RST = 1'b1;
        #1;
        chk("async_rst_valid", 64'(redirect_valid), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_pc", redirect_pc, 64'd0);
        rd(12'h341, 64'h0, "async_rst_mepc");
        rd(12'h305, 64'h8000_0000, "async_rst_mtvec");
        @(negedge CLK);
        RST = 1'b0;
        redirect_ready = 1'b1;
        repeat (3) @(negedge CLK);
        #3;
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("final_pops", 64'(pops), 64'(pushes));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
